// File: rtl/rv_muldiv_unit.sv
// rv_muldiv_unit: radix-2 iterative RISC-V M-extension multiply/divide unit,
// including the RV64 W forms. One product/quotient bit per cycle, with
// divide-by-zero, signed overflow and illegal W ops resolved without iterating.
module rv_muldiv_unit #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      funct3,
    input  logic            is_word,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);
    localparam int              SH  = XLEN - 32;
    localparam logic [XLEN-1:0] ONE = XLEN'(1);
    localparam logic [XLEN-1:0] MSB = ONE << (XLEN - 1);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

    state_t            state_q, state_d;
    logic [5:0]        cnt_q, cnt_d;
    logic [2:0]        f3_q, f3_d;
    logic              w_q, w_d, neg_q, neg_d, early_q, early_d;
    logic              vld_q, vld_d, busy_q, busy_d;
    logic [XLEN-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2*XLEN-1:0] acc_q, acc_d;

    function automatic logic [XLEN-1:0] sext32(input logic [XLEN-1:0] v);
        return $signed(v << SH) >>> SH;
    endfunction

    function automatic logic [XLEN-1:0] zext32(input logic [XLEN-1:0] v);
        return (v << SH) >> SH;
    endfunction

    // Accept-time decode: operand extension, magnitudes, sign record, early results
    logic            is_w, a_sgn, b_sgn, sa, sb, div0, ovf, ill, early_hit, rec_neg;
    logic [XLEN-1:0] ext_a, ext_b, mag_a, mag_b, minv, early_val;
    always_comb begin
        is_w  = (XLEN == 64) && is_word;
        a_sgn = funct3[2] ? ~funct3[0] : (funct3 != 3'b011);
        b_sgn = funct3[2] ? ~funct3[0] : ~funct3[1];
        ext_a = op_a;
        ext_b = op_b;
        if (is_w) begin
            ext_a = a_sgn ? sext32(op_a) : zext32(op_a);
            ext_b = b_sgn ? sext32(op_b) : zext32(op_b);
        end
        sa      = a_sgn & ext_a[XLEN-1];
        sb      = b_sgn & ext_b[XLEN-1];
        mag_a   = sa ? -ext_a : ext_a;
        mag_b   = sb ? -ext_b : ext_b;
        minv    = is_w ? sext32(MSB >> SH) : MSB;
        div0    = funct3[2] && (ext_b == '0);
        ovf     = funct3[2] && !funct3[0] && (ext_a == minv) && (ext_b == '1);
        ill     = is_w && !funct3[2] && (funct3[1:0] != 2'b00);
        rec_neg = (funct3[2] & funct3[1]) ? sa : (sa ^ sb);
        early_hit = div0 | ovf | ill;
        early_val = '0;
        if (div0)     early_val = funct3[1] ? ext_a : '1;
        else if (ovf) early_val = funct3[1] ? '0 : ext_a;
    end

    // One iteration: MSB-first shift-add multiply or restoring-divide step
    logic              a_bit, b_bit, ge;
    logic [XLEN:0]     rem_sh;
    logic [XLEN-1:0]   rem_new;
    logic [2*XLEN-1:0] step_acc;
    always_comb begin
        a_bit   = |(a_q & (ONE << cnt_q));
        b_bit   = |(b_q & (ONE << cnt_q));
        rem_sh  = {acc_q[2*XLEN-1:XLEN], a_bit};
        ge      = rem_sh >= {1'b0, b_q};
        rem_new = ge ? (rem_sh[XLEN-1:0] - b_q) : rem_sh[XLEN-1:0];
        if (f3_q[2]) step_acc = {rem_new, acc_q[XLEN-2:0], ge};
        else         step_acc = (acc_q << 1) + (b_bit ? {{XLEN{1'b0}}, a_q} : '0);
    end

    // Sign correction and final result select
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   qr, sel, fix_val;
    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        qr   = f3_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0];
        if (early_q)            sel = acc_q[XLEN-1:0];
        else if (f3_q[2])       sel = neg_q ? -qr : qr;
        else if (f3_q == 3'b000) sel = prod[XLEN-1:0];
        else                    sel = prod[2*XLEN-1:XLEN];
        fix_val = w_q ? sext32(sel) : sel;
    end

    // Next-state and register update logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        f3_d    = f3_q;
        w_d     = w_q;
        neg_d   = neg_q;
        early_d = early_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        res_d   = res_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && !flush) begin
                    f3_d    = funct3;
                    w_d     = is_w;
                    neg_d   = rec_neg;
                    early_d = early_hit;
                    a_d     = mag_a;
                    b_d     = mag_b;
                    cnt_d   = is_w ? 6'd31 : 6'(XLEN - 1);
                    acc_d   = early_hit ? {{XLEN{1'b0}}, early_val} : '0;
                    state_d = early_hit ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                acc_d = step_acc;
                if (cnt_q == 6'd0) state_d = S_FIX;
                else               cnt_d   = cnt_q - 6'd1;
            end
            S_FIX: begin
                res_d   = fix_val;
                state_d = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (flush) state_d = S_IDLE;
        vld_d  = (state_d == S_DONE);
        busy_d = (state_d == S_CALC) || (state_d == S_FIX);
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            f3_q    <= '0;
            w_q     <= 1'b0;
            neg_q   <= 1'b0;
            early_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            vld_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            f3_q    <= f3_d;
            w_q     <= w_d;
            neg_q   <= neg_d;
            early_q <= early_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            vld_q   <= vld_d;
            busy_q  <= busy_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = vld_q;
    assign busy      = busy_q;
    assign result    = res_q;
endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Self-checking bench for rv_muldiv_unit (XLEN=64): directed cases, latency,
// backpressure, back-to-back, flush and async reset, plus randomized ops
// checked against a reference model through a result scoreboard.
module tb_rv_muldiv_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  funct3 = '0;
    logic        is_word = 1'b0;
    logic [63:0] op_a = '0;
    logic [63:0] op_b = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [63:0] result;
    logic        busy;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;

    rv_muldiv_unit #(.XLEN(64)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .funct3(funct3), .is_word(is_word), .op_a(op_a), .op_b(op_b),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog expired errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Scoreboard: every drained result is compared with the oldest expectation
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result got=%h with nothing outstanding", result);
            end else begin
                mon_exp = exp_q.pop_front();
                if (result !== mon_exp) begin
                    errors++;
                    $display("FAIL result got=%h want=%h", result, mon_exp);
                end
            end
        end
    end

    function automatic logic [63:0] model(input logic [2:0] f3, input logic w,
                                          input logic [63:0] a, input logic [63:0] b);
        logic signed [127:0] sp;
        logic [127:0]        up;
        logic signed [31:0]  sa32, sb32;
        logic [31:0]         r32;
        logic [63:0]         r;
        sa32 = a[31:0];
        sb32 = b[31:0];
        r32  = '0;
        r    = '0;
        if (w) begin
            case (f3)
                3'b000: r32 = a[31:0] * b[31:0];
                3'b100: begin
                    if (b[31:0] == 32'd0) r32 = 32'hFFFFFFFF;
                    else if (a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF) r32 = a[31:0];
                    else r32 = sa32 / sb32;
                end
                3'b101: begin
                    if (b[31:0] == 32'd0) r32 = 32'hFFFFFFFF;
                    else r32 = a[31:0] / b[31:0];
                end
                3'b110: begin
                    if (b[31:0] == 32'd0) r32 = a[31:0];
                    else if (a[31:0] == 32'h80000000 && b[31:0] == 32'hFFFFFFFF) r32 = 32'd0;
                    else r32 = sa32 % sb32;
                end
                3'b111: begin
                    if (b[31:0] == 32'd0) r32 = a[31:0];
                    else r32 = a[31:0] % b[31:0];
                end
                default: return 64'd0;
            endcase
            return {{32{r32[31]}}, r32};
        end
        case (f3)
            3'b000: r = a * b;
            3'b001: begin sp = $signed({{64{a[63]}}, a}) * $signed({{64{b[63]}}, b}); r = sp[127:64]; end
            3'b010: begin sp = $signed({{64{a[63]}}, a}) * $signed({64'd0, b}); r = sp[127:64]; end
            3'b011: begin up = {64'd0, a} * {64'd0, b}; r = up[127:64]; end
            3'b100: begin
                if (b == 64'd0) r = '1;
                else if (a == 64'h8000000000000000 && b == '1) r = a;
                else r = $signed(a) / $signed(b);
            end
            3'b101: begin
                if (b == 64'd0) r = '1;
                else r = a / b;
            end
            3'b110: begin
                if (b == 64'd0) r = a;
                else if (a == 64'h8000000000000000 && b == '1) r = 64'd0;
                else r = $signed(a) % $signed(b);
            end
            default: begin
                if (b == 64'd0) r = a;
                else r = a % b;
            end
        endcase
        return r;
    endfunction

    task automatic send(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [63:0] exp, input bit track);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        funct3 = f3; is_word = w; op_a = a; op_b = b; in_valid = 1'b1;
        if (track) exp_q.push_back(exp);
        @(posedge clk); #1;
        acc_cyc  = cyc;
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        int n;
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin @(posedge clk); #1; n++; end
        lat = (out_valid === 1'b1) ? (cyc - acc_cyc + 1) : -1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b vld=%b busy=%b res=%h want 1 0 0 0",
                     in_ready, out_valid, busy, result);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL after_reset got rdy=%b busy=%b want 1 0", in_ready, busy);
        end
    endtask

    task automatic test_mul();
        int lat, n, bcnt;
        send(3'b000, 1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 1'b1);
        n = 0; bcnt = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clk); #1; n++;
        end
        lat = (out_valid === 1'b1) ? (cyc - acc_cyc + 1) : -1;
        checks++;
        if (lat !== 66) begin errors++; $display("FAIL mul_latency got=%0d want=66", lat); end
        checks++;
        if (bcnt !== 65) begin errors++; $display("FAIL mul_busy_cycles got=%0d want=65", bcnt); end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL mul_drain got vld=%b rdy=%b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_mulh();
        int lat;
        send(3'b011, 1'b0, '1, '1, 64'hFFFFFFFFFFFFFFFE, 1'b1);
        wait_out(lat);
        checks++;
        if (lat !== 66) begin errors++; $display("FAIL mulhu_latency got=%0d want=66", lat); end
        @(posedge clk); #1;
        send(3'b010, 1'b0, '1, 64'd2, 64'hFFFFFFFFFFFFFFFF, 1'b1);
        wait_out(lat); @(posedge clk); #1;
        send(3'b001, 1'b0, 64'h8000000000000000, 64'h8000000000000000, 64'h4000000000000000, 1'b1);
        wait_out(lat); @(posedge clk); #1;
    endtask

    task automatic test_early();
        logic [2:0]  f3s[4] = '{3'b100, 3'b111, 3'b100, 3'b110};
        logic [63:0] as[4]  = '{64'd5, 64'd5, 64'h8000000000000000, 64'h8000000000000000};
        logic [63:0] bs[4]  = '{64'd0, 64'd0, '1, '1};
        logic [63:0] es[4]  = '{'1, 64'd5, 64'h8000000000000000, 64'd0};
        int lat;
        for (int i = 0; i < 4; i++) begin
            send(f3s[i], 1'b0, as[i], bs[i], es[i], 1'b1);
            wait_out(lat);
            checks++;
            if (lat !== 2) begin errors++; $display("FAIL early_latency[%0d] got=%0d want=2", i, lat); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_word();
        logic [2:0]  f3s[4] = '{3'b100, 3'b110, 3'b000, 3'b001};
        logic [63:0] as[4]  = '{64'h00000000FFFFFFF9, 64'h00000000FFFFFFF9, 64'h7FFFFFFF, 64'h1234};
        logic [63:0] bs[4]  = '{64'd2, 64'd2, 64'd2, 64'h5678};
        logic [63:0] es[4]  = '{64'hFFFFFFFFFFFFFFFD, '1, 64'hFFFFFFFFFFFFFFFE, 64'd0};
        int          lw[4]  = '{34, 34, 34, 2};
        int lat;
        for (int i = 0; i < 4; i++) begin
            send(f3s[i], 1'b1, as[i], bs[i], es[i], 1'b1);
            wait_out(lat);
            checks++;
            if (lat !== lw[i]) begin errors++; $display("FAIL word_latency[%0d] got=%0d want=%0d", i, lat, lw[i]); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [63:0] r0;
        out_ready = 1'b0;
        send(3'b101, 1'b0, 64'd100, 64'd7, 64'd14, 1'b1);
        wait_out(lat);
        checks++;
        if (lat !== 66) begin errors++; $display("FAIL bp_latency got=%0d want=66", lat); end
        r0 = result;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (result !== r0 || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d] got res=%h rdy=%b vld=%b want res=%h rdy=0 vld=1",
                         i, result, in_ready, out_valid, r0);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release got rdy=%b vld=%b want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int lat, acc1, n;
        send(3'b000, 1'b1, 64'd3, 64'h00000000FFFFFFFB, 64'hFFFFFFFFFFFFFFF1, 1'b1);
        acc1 = acc_cyc;
        funct3 = 3'b111; is_word = 1'b1; op_a = 64'h0000000100000011; op_b = 64'd5; in_valid = 1'b1;
        exp_q.push_back(64'd2);
        wait_out(lat);
        checks++;
        if (lat !== 34 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first got lat=%0d rdy=%b want lat=34 rdy=0", lat, in_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_accept_in_drain got vld=%b rdy=%b busy=%b want 0 1 0",
                     out_valid, in_ready, busy);
        end
        @(posedge clk); #1;
        acc_cyc = cyc; in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || (acc_cyc - acc1) !== 35) begin
            errors++;
            $display("FAIL b2b_second_accept got busy=%b gap=%0d want busy=1 gap=35", busy, acc_cyc - acc1);
        end
        n = 0;
        wait_out(lat); @(posedge clk); #1;
    endtask

    task automatic test_flush();
        int lat, seen;
        send(3'b000, 1'b0, 64'd11, 64'd13, 64'd0, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        flush = 1'b1; in_valid = 1'b1; funct3 = 3'b000; op_a = 64'd2; op_b = 64'd2;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_calc got rdy=%b busy=%b vld=%b want 1 0 0", in_ready, busy, out_valid);
        end
        flush = 1'b1; in_valid = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_blocks_accept got rdy=%b busy=%b want 1 0", in_ready, busy);
        end
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk); #1;
            if (out_valid === 1'b1) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL flush_no_output got=%0d valid cycles want=0", seen); end
        send(3'b000, 1'b0, 64'd123, 64'd456, 64'd56088, 1'b1);
        wait_out(lat);
        checks++;
        if (lat !== 66) begin errors++; $display("FAIL flush_recover_latency got=%0d want=66", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_fix();
        int lat;
        send(3'b000, 1'b1, 64'h7FFFFFFF, 64'd2, 64'd0, 1'b0);
        repeat (32) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL fix_state got busy=%b vld=%b want 1 0", busy, out_valid);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 64'd0) begin
            errors++;
            $display("FAIL async_reset got rdy=%b vld=%b busy=%b res=%h want 1 0 0 0",
                     in_ready, out_valid, busy, result);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        send(3'b100, 1'b0, 64'd100, 64'hFFFFFFFFFFFFFFF9, 64'hFFFFFFFFFFFFFFF2, 1'b1);
        wait_out(lat);
        checks++;
        if (lat !== 66) begin errors++; $display("FAIL reset_recover_latency got=%0d want=66", lat); end
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat;
        logic [2:0]  f3;
        logic        w;
        logic [63:0] a, b;
        for (int i = 0; i < 10; i++) begin
            f3 = 3'($urandom_range(0, 7));
            w  = 1'($urandom_range(0, 1));
            a  = {$urandom, $urandom};
            b  = ($urandom_range(0, 3) == 0) ? 64'($urandom_range(0, 9)) : {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = -a;
            send(f3, w, a, b, model(f3, w, a, b), 1'b1);
            wait_out(lat);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_mul();
        test_mulh();
        test_early();
        test_word();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_reset_mid_fix();
        test_random();
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL outstanding_results got=%0d want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
